bclk_training_ctrl: RTL and testbench

- Fabric-side training sequencer that drives the delay-line and eye-monitor controls of the DDR3 BCLK-training IOD and consumes its deserialised RX data.
- After a START request it reloads the delay line and sweeps it upward one tap at a time, classifying each tap's 8-bit sample stream.
- It reports the first tap at which the captured BCLK phase flips, giving the edge position for the DDR3 PHY lane-control logic.

---
 rtl/bclk_training_pkg.sv | 33 +++
 rtl/bclk_sample_window.sv | 76 +++++++
 rtl/bclk_training_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bclk_training_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bclk_training_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bclk_training_pkg
// Brief    : Shared state encoding, tap classes and pattern defaults for the
//            BCLK training sequencer.
// Revision : 1.0
// ============================================================================
package bclk_training_pkg;

    localparam int c_tap_w = 8;

    localparam logic [7:0] c_pattern_a_def = 8'h55;
    localparam logic [7:0] c_pattern_b_def = 8'hAA;

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_load   = 4'd1;
    localparam logic [3:0] c_st_clear  = 4'd2;
    localparam logic [3:0] c_st_settle = 4'd3;
    localparam logic [3:0] c_st_sample = 4'd4;
    localparam logic [3:0] c_st_eval   = 4'd5;
    localparam logic [3:0] c_st_step   = 4'd6;
    localparam logic [3:0] c_st_done   = 4'd7;
    localparam logic [3:0] c_st_fail   = 4'd8;

    typedef enum logic [1:0] {
        CLS_NONE     = 2'd0,
        CLS_A        = 2'd1,
        CLS_B        = 2'd2,
        CLS_UNSTABLE = 2'd3
    } tap_class_e;

endpackage
`default_nettype wire

// File: rtl/bclk_sample_window.sv
`default_nettype none
// ============================================================================
// Module   : bclk_sample_window
// Brief    : Examines one tap's RX window: latches the first word, checks that
//            all words repeat a legal pattern and ORs the eye-monitor flags.
// Revision : 1.0
// ============================================================================
module bclk_sample_window
    import bclk_training_pkg::*;
#(
    parameter int         SAMPLE_WINDOW = 16,
    parameter logic [7:0] PATTERN_A     = c_pattern_a_def,
    parameter logic [7:0] PATTERN_B     = c_pattern_b_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_rx_data,
    input  logic       i_early,
    input  logic       i_late,
    output logic       o_stable,
    output logic       o_eye_hit,
    output logic       o_window_done,
    output logic [7:0] o_first_word
);

    localparam logic [7:0] c_last = 8'(SAMPLE_WINDOW - 1);

    logic       r_active;
    logic [7:0] r_count;
    logic [7:0] r_first;
    logic       r_stable;
    logic       r_eye_hit;

    logic w_first_cycle;
    logic w_last;
    logic w_legal;

    assign w_first_cycle = (r_count == 8'd0);
    assign w_last        = r_active && (r_count == c_last);
    assign w_legal       = (i_rx_data == PATTERN_A) || (i_rx_data == PATTERN_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_count   <= 8'd0;
            r_first   <= 8'd0;
            r_stable  <= 1'b0;
            r_eye_hit <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= 8'd0;
        end else if (r_active) begin
            // The first word seeds the compare; later words must repeat it.
            if (w_first_cycle) begin
                r_first   <= i_rx_data;
                r_stable  <= w_legal;
                r_eye_hit <= i_early | i_late;
            end else begin
                r_stable  <= r_stable && (i_rx_data == r_first);
                r_eye_hit <= r_eye_hit | i_early | i_late;
            end
            r_count <= r_count + 8'd1;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_stable      = r_stable;
    assign o_eye_hit     = r_eye_hit;
    assign o_window_done = w_last;
    assign o_first_word  = r_first;

endmodule
`default_nettype wire

// File: rtl/bclk_training_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bclk_training_ctrl
// Brief    : Sweeps the BCLK delay line upward and reports the first tap at
//            which the captured BCLK phase flips.
// Revision : 1.0
// ============================================================================
module bclk_training_ctrl
    import bclk_training_pkg::*;
#(
    parameter int         TAP_MAX       = 127,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         SAMPLE_WINDOW = 16,
    parameter logic [7:0] PATTERN_A     = c_pattern_a_def,
    parameter logic [7:0] PATTERN_B     = c_pattern_b_def
) (
    input  logic               FAB_CLK,
    input  logic               ARST_N,
    input  logic               START,
    input  logic [7:0]         RX_DATA_0,
    input  logic               EYE_MONITOR_EARLY_0,
    input  logic               EYE_MONITOR_LATE_0,
    input  logic               DELAY_LINE_OUT_OF_RANGE_0,
    output logic               DELAY_LINE_LOAD_0,
    output logic               DELAY_LINE_MOVE_0,
    output logic               DELAY_LINE_DIRECTION_0,
    output logic               EYE_MONITOR_CLEAR_FLAGS_0,
    output logic               BUSY,
    output logic               DONE,
    output logic               FAIL,
    output logic [c_tap_w-1:0] TAP_OUT
);

    localparam logic [c_tap_w-1:0] c_tap_max     = c_tap_w'(TAP_MAX);
    localparam logic [7:0]         c_settle_last = 8'(SETTLE_CYCLES - 1);

    logic [3:0]         r_state;
    logic [c_tap_w-1:0] r_tap;
    logic [7:0]         r_settle_cnt;
    tap_class_e         r_ref_class;
    logic               r_load;
    logic               r_move;
    logic               r_dir;
    logic               r_clear;
    logic               r_busy;
    logic               r_done;
    logic               r_fail;
    logic [c_tap_w-1:0] r_tap_out;

    logic [3:0] w_state_nxt;
    logic       w_accept;
    logic       w_busy_nxt;
    logic       w_settle_done;
    logic       w_win_start;
    logic       w_stable;
    logic       w_eye_hit;
    logic       w_window_done;
    logic [7:0] w_first;
    tap_class_e w_class;
    logic       w_found;
    logic       w_oor;

    assign w_oor         = DELAY_LINE_OUT_OF_RANGE_0;
    assign w_settle_done = (r_settle_cnt == c_settle_last);
    assign w_win_start   = (r_state == c_st_settle) && w_settle_done && !w_oor;
    assign w_accept      = START && ((r_state == c_st_idle) || (r_state == c_st_done) ||
                                     (r_state == c_st_fail));

    bclk_sample_window #(
        .SAMPLE_WINDOW (SAMPLE_WINDOW),
        .PATTERN_A     (PATTERN_A),
        .PATTERN_B     (PATTERN_B)
    ) u_sample_window (
        .clk           (FAB_CLK),
        .rst_n         (ARST_N),
        .i_start       (w_win_start),
        .i_rx_data     (RX_DATA_0),
        .i_early       (EYE_MONITOR_EARLY_0),
        .i_late        (EYE_MONITOR_LATE_0),
        .o_stable      (w_stable),
        .o_eye_hit     (w_eye_hit),
        .o_window_done (w_window_done),
        .o_first_word  (w_first)
    );

    // A stable window can only hold PATTERN_A or PATTERN_B.
    always_comb begin
        w_class = CLS_UNSTABLE;
        if (w_stable && !w_eye_hit) begin
            w_class = (w_first == PATTERN_A) ? CLS_A : CLS_B;
        end
    end

    assign w_found = (r_ref_class != CLS_NONE) && (w_class != CLS_UNSTABLE) &&
                     (w_class != r_ref_class);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done, c_st_fail: begin
                if (w_accept) w_state_nxt = c_st_load;
            end
            c_st_load:   w_state_nxt = c_st_clear;
            c_st_clear:  w_state_nxt = w_oor ? c_st_fail : c_st_settle;
            c_st_settle: begin
                if (w_oor)              w_state_nxt = c_st_fail;
                else if (w_settle_done) w_state_nxt = c_st_sample;
            end
            c_st_sample: begin
                if (w_oor)              w_state_nxt = c_st_fail;
                else if (w_window_done) w_state_nxt = c_st_eval;
            end
            c_st_eval: begin
                if (w_oor)                   w_state_nxt = c_st_fail;
                else if (w_found)            w_state_nxt = c_st_done;
                else if (r_tap == c_tap_max) w_state_nxt = c_st_fail;
                else                         w_state_nxt = c_st_step;
            end
            c_st_step:   w_state_nxt = w_oor ? c_st_fail : c_st_clear;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_done) &&
                        (w_state_nxt != c_st_fail);

    // Outputs are decoded from the next state so each one is a clean register.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state      <= c_st_idle;
            r_tap        <= '0;
            r_settle_cnt <= 8'd0;
            r_ref_class  <= CLS_NONE;
            r_load       <= 1'b0;
            r_move       <= 1'b0;
            r_dir        <= 1'b0;
            r_clear      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_tap_out    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_load  <= (w_state_nxt == c_st_load);
            r_clear <= (w_state_nxt == c_st_clear);
            r_move  <= (w_state_nxt == c_st_step);
            r_busy  <= w_busy_nxt;
            r_dir   <= w_busy_nxt;
            r_done  <= (w_state_nxt == c_st_done);
            r_fail  <= (w_state_nxt == c_st_fail);

            if (r_state == c_st_clear) begin
                r_settle_cnt <= 8'd0;
            end else if (r_state == c_st_settle) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end

            if (w_accept) begin
                r_tap       <= '0;
                r_ref_class <= CLS_NONE;
                r_tap_out   <= '0;
            end else if (r_state == c_st_step) begin
                r_tap <= r_tap + 1'b1;
            end else if (r_state == c_st_eval) begin
                if ((r_ref_class == CLS_NONE) && (w_class != CLS_UNSTABLE)) begin
                    r_ref_class <= w_class;
                end
                if (w_state_nxt == c_st_done) begin
                    r_tap_out <= r_tap;
                end
            end
        end
    end

    assign DELAY_LINE_LOAD_0         = r_load;
    assign DELAY_LINE_MOVE_0         = r_move;
    assign DELAY_LINE_DIRECTION_0    = r_dir;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = r_clear;
    assign BUSY                      = r_busy;
    assign DONE                      = r_done;
    assign FAIL                      = r_fail;
    assign TAP_OUT                   = r_tap_out;

endmodule
`default_nettype wire

// File: tb/tb_bclk_training_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bclk_training_ctrl
// Brief    : Directed sweeps against a cycle-timeline model of the sequencer.
// Revision : 1.0
// ============================================================================
module tb_bclk_training_ctrl;

    localparam int TAP_MAX    = 127;
    localparam int SETTLE     = 8;
    localparam int WINDOW     = 16;
    localparam int PERIOD     = 1 + SETTLE + WINDOW + 1 + 1;
    localparam int FIRST_MOVE = 1 + 1 + 1 + SETTLE + WINDOW + 1;

    logic       FAB_CLK;
    logic       ARST_N;
    logic       START;
    logic [7:0] RX_DATA_0;
    logic       EYE_MONITOR_EARLY_0;
    logic       EYE_MONITOR_LATE_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       EYE_MONITOR_CLEAR_FLAGS_0;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [7:0] TAP_OUT;

    bclk_training_ctrl #(
        .TAP_MAX       (TAP_MAX),
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_WINDOW (WINDOW),
        .PATTERN_A     (8'h55),
        .PATTERN_B     (8'hAA)
    ) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .START                     (START),
        .RX_DATA_0                 (RX_DATA_0),
        .EYE_MONITOR_EARLY_0       (EYE_MONITOR_EARLY_0),
        .EYE_MONITOR_LATE_0        (EYE_MONITOR_LATE_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .EYE_MONITOR_CLEAR_FLAGS_0 (EYE_MONITOR_CLEAR_FLAGS_0),
        .BUSY                      (BUSY),
        .DONE                      (DONE),
        .FAIL                      (FAIL),
        .TAP_OUT                   (TAP_OUT)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_moves  = 0;

    // Model of the current sweep as a timeline anchored at the START cycle.
    bit         m_active = 1'b0;
    int         m_start  = 0;
    int         m_end    = 0;
    bit         m_end_fail = 1'b0;
    logic [7:0] m_tap_out = 8'd0;
    int         m_scn    = 0;
    bit         p_done   = 1'b0;
    bit         p_fail   = 1'b0;
    logic [7:0] p_tap    = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [14:0] out_vec();
        return {DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
                EYE_MONITOR_CLEAR_FLAGS_0, BUSY, DONE, FAIL, TAP_OUT};
    endfunction

    function automatic logic [14:0] exp_vec(int c);
        logic ld, mv, dr, cl, bz, dn, fl;
        logic [7:0] tp;
        int rel;
        ld = 0; mv = 0; dr = 0; cl = 0; bz = 0;
        dn = p_done; fl = p_fail; tp = p_tap;
        if (m_active && c > m_start) begin
            rel = c - m_start;
            if (c >= m_end) begin
                dn = !m_end_fail; fl = m_end_fail; tp = m_tap_out;
            end else begin
                bz = 1; dr = 1; dn = 0; fl = 0; tp = 8'd0;
                ld = (rel == 1);
                cl = (rel >= 2) && ((rel - 2) % PERIOD == 0);
                mv = (rel >= FIRST_MOVE) && ((rel - FIRST_MOVE) % PERIOD == 0);
            end
        end
        return {ld, mv, dr, cl, bz, dn, fl, tp};
    endfunction

    // Tap the delay line is expected to sit at in cycle c of the current sweep.
    function automatic int cur_tap(int c);
        if (!m_active || c < m_start + 2) return 0;
        return (c - m_start - 2) / PERIOD;
    endfunction

    function automatic logic [7:0] rx_of(int scn, int tap, int c);
        case (scn)
            0, 3:    return (tap < 10) ? 8'h55 : 8'hAA;
            1: begin
                if (tap < 5) return 8'hAA;
                if (tap < 8) return (c % 2 == 1) ? 8'h3C : 8'hAA;
                return 8'h55;
            end
            5:       return (tap < 2) ? 8'h55 : 8'hAA;
            default: return 8'h55;
        endcase
    endfunction

    // Hand-assigned tap classes per scenario: 1=A(55) 2=B(AA) 3=unstable.
    function automatic int class_of(int scn, int tap);
        case (scn)
            0:       return (tap < 10) ? 1 : 2;
            1:       return (tap < 5) ? 2 : (tap < 8) ? 3 : 1;
            3:       return (tap < 10) ? 1 : (tap == 10) ? 3 : 2;
            5:       return (tap < 2) ? 1 : 2;
            default: return 1;
        endcase
    endfunction

    function automatic int edge_tap(int scn);
        int rc;
        int c;
        rc = 0;
        for (int t = 0; t <= TAP_MAX; t++) begin
            c = class_of(scn, t);
            if (c != 3) begin
                if (rc == 0) rc = c;
                else if (c != rc) return t;
            end
        end
        return -1;
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge FAB_CLK); #1;
        end
    endtask

    task automatic start_sweep(input int scn);
        int t;
        if (m_active) begin
            p_done = !m_end_fail; p_fail = m_end_fail; p_tap = m_tap_out;
        end
        m_scn   = scn;
        n_moves = 0;
        START   = 1'b1;
        m_start = cyc;
        m_active = 1'b1;
        t = edge_tap(scn);
        m_end_fail = (t < 0);
        m_tap_out  = (t < 0) ? 8'd0 : 8'(t);
        m_end = m_start + FIRST_MOVE + PERIOD * ((t < 0) ? TAP_MAX : t);
        @(posedge FAB_CLK); #1;
        START = 1'b0;
    endtask

    task automatic finish_sweep(input int moves, input bit fail, input int tap);
        wait_until(m_end + 1);
        check("done_level", DONE, !fail);
        check("fail_level", FAIL, fail);
        check("tap_out", TAP_OUT, tap);
        check("busy_idle", BUSY, 0);
        check("move_count", n_moves, moves);
    endtask

    // Eye-monitor / IOD stimulus following the model's tap position.
    initial begin
        RX_DATA_0 = 8'h00;
        EYE_MONITOR_EARLY_0 = 1'b0;
        EYE_MONITOR_LATE_0  = 1'b0;
        forever begin
            @(posedge FAB_CLK); #2;
            RX_DATA_0 = rx_of(m_scn, cur_tap(cyc), cyc);
            EYE_MONITOR_EARLY_0 = (m_scn == 3) && (cur_tap(cyc) == 10) && (cyc % 4 == 1);
        end
    end

    initial begin
        forever begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE_0) n_moves++;
            check("cycle_outputs", out_vec(), exp_vec(cyc));
        end
    end

    initial begin
        START = 1'b0;
        ARST_N = 1'b0;
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        repeat (3) @(posedge FAB_CLK);
        #1;
        check("reset_outputs", out_vec(), 0);
        ARST_N = 1'b1;
        repeat (2) @(posedge FAB_CLK);
        #1;

        // Edge 55 -> AA at tap 10; a START mid-sweep must be ignored.
        start_sweep(0);
        check("load_after_start", DELAY_LINE_LOAD_0, 1);
        wait_until(m_start + 50);
        START = 1'b1;
        @(posedge FAB_CLK); #1;
        START = 1'b0;
        finish_sweep(10, 0, 10);

        // Garbage taps 5..7 must not produce an early edge.
        start_sweep(1);
        finish_sweep(8, 0, 8);

        // Eye-monitor hit makes tap 10 unstable; edge lands on 11.
        start_sweep(3);
        finish_sweep(11, 0, 11);

        // Out-of-range during SETTLE of tap 3.
        start_sweep(4);
        wait_until(m_start + 2 + 3 * PERIOD + 3);
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
        m_end = cyc + 1; m_end_fail = 1'b1; m_tap_out = 8'd0;
        @(posedge FAB_CLK); #1;
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        finish_sweep(3, 1, 0);

        // No edge anywhere: fail after tap TAP_MAX.
        start_sweep(2);
        finish_sweep(127, 1, 0);
        check("direction_idle", DELAY_LINE_DIRECTION_0, 0);

        // Reset during SAMPLE of tap 6, then a fresh sweep.
        start_sweep(0);
        wait_until(m_start + 2 + 6 * PERIOD + 1 + SETTLE + 5);
        ARST_N = 1'b0;
        m_active = 1'b0; p_done = 1'b0; p_fail = 1'b0; p_tap = 8'd0;
        #1;
        check("async_reset_clears", out_vec(), 0);
        repeat (3) @(posedge FAB_CLK);
        #1;
        ARST_N = 1'b1;
        repeat (2) @(posedge FAB_CLK);
        #1;
        start_sweep(5);
        check("load_after_reset", DELAY_LINE_LOAD_0, 1);
        finish_sweep(2, 0, 2);

        repeat (3) @(posedge FAB_CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
